// File: rtl/multi_mode_ff_bank.sv
// WIDTH-bit register bank with per-cycle selectable D/T/JK/SR update law, edge pulses and sticky SR error.
// Define FF_BANK_CHG_CNT_EN to build the saturating change counter; otherwise chg_cnt_o is tied to 0.
module multi_mode_ff_bank #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
    parameter int               CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             err_clr_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] q_n_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             sr_err_o,
    output logic [CNT_W-1:0] chg_cnt_o
);

    localparam logic [1:0] MODE_D  = 2'b00;
    localparam logic [1:0] MODE_T  = 2'b01;
    localparam logic [1:0] MODE_JK = 2'b10;
    localparam logic [1:0] MODE_SR = 2'b11;

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             sr_err_q, sr_err_d;
    logic             sr_set;

    always_comb begin
        q_d = q_q;
        if (en_i) begin
            unique case (mode_i)
                MODE_D:  q_d = a_i;
                MODE_T:  q_d = q_q ^ a_i;
                MODE_JK: q_d = (a_i & ~q_q) | (~b_i & q_q);
                // S=R=1 falls into the hold term, so invalid bits keep their value
                MODE_SR: q_d = (a_i & ~b_i) | (q_q & ~(~a_i & b_i));
                default: q_d = q_q;
            endcase
        end
        sr_set   = en_i && (mode_i == MODE_SR) && (|(a_i & b_i));
        rise_d   = q_d & ~q_q;
        fall_d   = ~q_d & q_q;
        sr_err_d = sr_err_q;
        if (sr_set) begin
            sr_err_d = 1'b1;
        end else if (err_clr_i) begin
            sr_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q      <= RST_VAL;
            rise_q   <= '0;
            fall_q   <= '0;
            sr_err_q <= 1'b0;
        end else begin
            q_q      <= q_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            sr_err_q <= sr_err_d;
        end
    end

`ifdef FF_BANK_CHG_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if ((q_d != q_q) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign chg_cnt_o = cnt_q;
`else
    assign chg_cnt_o = '0;
`endif

    assign q_o      = q_q;
    assign q_n_o    = ~q_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign sr_err_o = sr_err_q;

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// Bench for multi_mode_ff_bank: directed scenarios plus random traffic against a per-bit truth-table model.
module tb_multi_mode_ff_bank;

    localparam int         WIDTH   = 8;
    localparam logic [7:0] RST_VAL = 8'hA5;
    localparam int         CNT_W   = 4;
`ifdef FF_BANK_CHG_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic             clk_i = 1'b0;
    logic             rst_i, en_i, err_clr_i;
    logic [1:0]       mode_i;
    logic [WIDTH-1:0] a_i, b_i;
    logic [WIDTH-1:0] q_o, q_n_o, rise_o, fall_o;
    logic             sr_err_o;
    logic [CNT_W-1:0] chg_cnt_o;

    multi_mode_ff_bank #(.WIDTH(WIDTH), .RST_VAL(RST_VAL), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .mode_i(mode_i),
        .a_i(a_i), .b_i(b_i), .err_clr_i(err_clr_i),
        .q_o(q_o), .q_n_o(q_n_o), .rise_o(rise_o), .fall_o(fall_o),
        .sr_err_o(sr_err_o), .chg_cnt_o(chg_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] m_q, m_rise, m_fall;
    logic       m_err;
    int         m_cnt;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Next value of one bit from the textbook characteristic tables.
    function automatic bit law(input logic [1:0] mode, input bit q, input bit a, input bit b);
        case (mode)
            2'd0: return a;
            2'd1: return a ? !q : q;
            2'd2: case ({a, b})
                      2'b00: return q;
                      2'b01: return 1'b0;
                      2'b10: return 1'b1;
                      default: return !q;
                  endcase
            default: case ({a, b})
                      2'b01: return 1'b0;
                      2'b10: return 1'b1;
                      default: return q;
                  endcase
        endcase
    endfunction

    task automatic check_all();
        chk("q", {8'h0, q_o}, {8'h0, m_q});
        chk("q_n", {8'h0, q_n_o}, {8'h0, ~m_q});
        chk("rise", {8'h0, rise_o}, {8'h0, m_rise});
        chk("fall", {8'h0, fall_o}, {8'h0, m_fall});
        chk("sr_err", {15'h0, sr_err_o}, {15'h0, m_err});
        chk("chg_cnt", {12'h0, chg_cnt_o}, CNT_ON ? 16'(m_cnt) : 16'h0);
    endtask

    task automatic tick();
        logic [7:0] nq;
        bit         set_err;
        @(posedge clk_i);
        if (rst_i) begin
            m_q = RST_VAL; m_rise = 0; m_fall = 0; m_err = 0; m_cnt = 0;
        end else begin
            nq      = m_q;
            set_err = 0;
            if (en_i) begin
                for (int i = 0; i < 8; i++) begin
                    nq[i] = law(mode_i, m_q[i], a_i[i], b_i[i]);
                    if (mode_i == 2'd3 && a_i[i] && b_i[i]) set_err = 1;
                end
            end
            m_rise = 0; m_fall = 0;
            for (int i = 0; i < 8; i++) begin
                if (!m_q[i] && nq[i]) m_rise[i] = 1'b1;
                if (m_q[i] && !nq[i]) m_fall[i] = 1'b1;
            end
            if (nq != m_q && m_cnt < 15) m_cnt++;
            if (set_err) m_err = 1;
            else if (err_clr_i) m_err = 0;
            m_q = nq;
        end
        #1;
        check_all();
    endtask

    task automatic drive(input bit rst, input bit en, input logic [1:0] mode,
                         input logic [7:0] a, input logic [7:0] b, input bit clr);
        rst_i = rst; en_i = en; mode_i = mode; a_i = a; b_i = b; err_clr_i = clr;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0);
        tick(); tick();
        chk("rst_q", {8'h0, q_o}, 16'h00A5);
        chk("rst_qn", {8'h0, q_n_o}, 16'h005A);
        chk("rst_cnt", {12'h0, chg_cnt_o}, 16'h0);

        drive(0, 1, 2'd0, 8'h0F, 0, 0); tick();
        chk("d_q1", {8'h0, q_o}, 16'h000F);
        drive(0, 1, 2'd0, 8'hF0, 0, 0); tick();
        chk("d_q2", {8'h0, q_o}, 16'h00F0);
        chk("d_rise", {8'h0, rise_o}, 16'h00F0);
        chk("d_fall", {8'h0, fall_o}, 16'h000F);
        chk("d_cnt", {12'h0, chg_cnt_o}, CNT_ON ? 16'd2 : 16'd0);

        drive(0, 1, 2'd0, 8'h00, 0, 0); tick();
        drive(0, 1, 2'd1, 8'h81, 0, 0);
        tick(); chk("t_q1", {8'h0, q_o}, 16'h0081); chk("t_r1", {8'h0, rise_o}, 16'h0081);
        tick(); chk("t_q2", {8'h0, q_o}, 16'h0000); chk("t_f2", {8'h0, fall_o}, 16'h0081);
        tick(); chk("t_q3", {8'h0, q_o}, 16'h0081); chk("t_r3", {8'h0, rise_o}, 16'h0081);

        drive(0, 1, 2'd0, 8'h0F, 0, 0); tick();
        drive(0, 1, 2'd2, 8'hCC, 8'hAA, 0); tick();
        chk("jk_q", {8'h0, q_o}, 16'h00C5);
        drive(0, 0, 2'd3, 8'hFF, 8'hFF, 0); tick(); tick();
        chk("hold_q", {8'h0, q_o}, 16'h00C5);
        chk("hold_err", {15'h0, sr_err_o}, 16'h0);

        drive(0, 1, 2'd0, 8'h00, 0, 0); tick();
        drive(0, 1, 2'd3, 8'h03, 8'h01, 0); tick();
        chk("sr_q", {8'h0, q_o}, 16'h0002);
        chk("sr_err_set", {15'h0, sr_err_o}, 16'h1);
        drive(0, 1, 2'd3, 8'h03, 8'h01, 1); tick();
        chk("sr_err_win", {15'h0, sr_err_o}, 16'h1);
        drive(0, 1, 2'd3, 8'h03, 8'h00, 1); tick();
        chk("sr_err_clr", {15'h0, sr_err_o}, 16'h0);

        drive(1, 0, 0, 0, 0, 0); tick();
        drive(0, 1, 2'd1, 8'h01, 0, 0);
        for (int i = 0; i < 20; i++) tick();
        chk("sat_cnt", {12'h0, chg_cnt_o}, CNT_ON ? 16'd15 : 16'd0);

        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                  ($urandom_range(0, 3) == 0));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
